// File: rtl/morse_pkg.sv
// morse_pkg: shared state encoding and letter pattern/length tables for the Morse sequencer
package morse_pkg;

    localparam int PATTERN_W = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Left-aligned on/off unit patterns, index 0 = A ... 7 = H
    localparam logic [7:0][PATTERN_W-1:0] PATTERN = {
        12'b1010_1010_0000,  // H
        12'b1110_1110_1000,  // G
        12'b1010_1110_1000,  // F
        12'b1000_0000_0000,  // E
        12'b1110_1010_0000,  // D
        12'b1110_1011_1010,  // C
        12'b1110_1010_1000,  // B
        12'b1011_1000_0000   // A
    };

    // Number of units on air for each letter
    localparam logic [7:0][3:0] LENGTH = {
        4'd7, 4'd9, 4'd9, 4'd1, 4'd7, 4'd11, 4'd9, 4'd5
    };

endpackage

// File: rtl/morse_sequencer_rate_divider.sv
// rate_divider: down-counter producing one tick per TICK_COUNT clock cycles
module rate_divider
    import morse_pkg::*;
#(
    parameter int TICK_COUNT = 25000000
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    output logic tick
);

    localparam int CW = $clog2(TICK_COUNT);
    localparam logic [CW-1:0] RELOAD = CW'(TICK_COUNT - 1);

    logic [CW-1:0] tick_cnt;

    assign tick = tick_cnt == '0;

    // Restart the unit on load, reload at zero, otherwise count down
    always_ff @(posedge clock) begin
        if (reset)
            tick_cnt <= '0;
        else
            tick_cnt <= (load || tick) ? RELOAD : tick_cnt - 1'b1;
    end

endmodule

// File: rtl/morse_sequencer.sv
// morse_sequencer: loads a letter pattern and shifts it out one Morse unit per tick
module morse_sequencer
    import morse_pkg::*;
#(
    parameter int TICK_COUNT = 25000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] letter_sel,
    input  logic       start,
    output logic       morse_out,
    output logic       busy,
    output logic       done
);

    state_t                 state, state_n;
    logic [PATTERN_W-1:0]   shift_reg, shift_n;
    logic [3:0]             len_cnt, len_n;
    logic                   start_q;
    logic                   start_pulse;
    logic                   load;
    logic                   tick;

    assign start_pulse = start & ~start_q;
    assign load        = state == LOAD;

    rate_divider #(.TICK_COUNT(TICK_COUNT)) u_div (
        .clock(clock),
        .reset(reset),
        .load (load),
        .tick (tick)
    );

    // Next state, shift register and length counter
    always_comb begin
        state_n = state;
        shift_n = shift_reg;
        len_n   = len_cnt;
        case (state)
            IDLE: state_n = start_pulse ? LOAD : IDLE;
            LOAD: begin
                shift_n = PATTERN[letter_sel];
                len_n   = LENGTH[letter_sel];
                state_n = SHIFT;
            end
            SHIFT: begin
                if (tick && len_cnt > 4'd1) begin
                    shift_n = shift_reg << 1;
                    len_n   = len_cnt - 4'd1;
                end
                state_n = (tick && len_cnt <= 4'd1) ? DONE : SHIFT;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State registers; outputs registered from next-state so they line up with the state
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            len_cnt   <= '0;
            start_q   <= 1'b0;
            morse_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            shift_reg <= shift_n;
            len_cnt   <= len_n;
            start_q   <= start;
            morse_out <= (state_n == SHIFT) & shift_n[PATTERN_W-1];
            busy      <= (state_n == LOAD) || (state_n == SHIFT);
            done      <= state_n == DONE;
        end
    end

endmodule

// File: tb/tb_morse_sequencer.sv
// tb_morse_sequencer: directed and randomized transmissions checked against a Morse-rule model
module tb_morse_sequencer;

    localparam int T = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [2:0] letter_sel = 3'd0;
    logic       morse_out, busy, done;

    int total = 0;
    int bad   = 0;

    string codes [8] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};

    morse_sequencer #(.TICK_COUNT(T)) dut (
        .clock     (clock),
        .reset     (reset),
        .letter_sel(letter_sel),
        .start     (start),
        .morse_out (morse_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [2:0] exp);
        logic [2:0] got;
        got = {morse_out, busy, done};
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: {morse_out,busy,done} got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic idle(input int n, input string tag);
        repeat (n) begin
            @(negedge clock);
            chk(tag, 3'b000);
        end
    endtask

    // Builds the expected cycle trace from dot/dash rules and compares every cycle.
    // hold keeps start high, noise re-pulses start and scrambles letter_sel after LOAD,
    // abort_at raises reset before that trace index.
    task automatic run_tx(input int sel, input bit hold, input bit noise, input int abort_at);
        bit         u[$];
        logic [2:0] tr[$];
        string      c;
        bit         aborted;
        c = codes[sel];
        aborted = 1'b0;
        for (int i = 0; i < c.len(); i++) begin
            if (i != 0) u.push_back(1'b0);
            if (c[i] == "-") repeat (3) u.push_back(1'b1);
            else u.push_back(1'b1);
        end
        tr.push_back(3'b010);
        foreach (u[k]) repeat (T) tr.push_back({u[k], 2'b10});
        tr.push_back(3'b001);
        tr.push_back(3'b000);
        letter_sel = 3'(sel);
        start = 1'b1;
        foreach (tr[i]) begin
            if (i == abort_at) begin
                reset = 1'b1;
                aborted = 1'b1;
                break;
            end
            @(negedge clock);
            chk($sformatf("tx%0d[%0d]", sel, i), tr[i]);
            if (!hold && i == 0) start = 1'b0;
            if (noise && i < tr.size() - 3) begin
                start = 1'($urandom_range(0, 1));
                if (i >= 1) letter_sel = 3'($urandom_range(0, 7));
            end
        end
        if (aborted) begin
            start = 1'b0;
            @(negedge clock);
            chk("abort_now", 3'b000);
            @(negedge clock);
            chk("abort_hold", 3'b000);
            reset = 1'b0;
            idle(4, "abort_after");
        end
    endtask

    initial begin
        repeat (3) begin
            @(negedge clock);
            chk("reset", 3'b000);
            start = ~start;
        end
        start = 1'b0;
        reset = 1'b0;
        idle(3, "idle_after_reset");

        run_tx(4, 1'b0, 1'b0, -1);
        idle(2, "after_e");
        run_tx(0, 1'b0, 1'b0, -1);
        idle(2, "after_a");

        run_tx(2, 1'b1, 1'b0, -1);
        idle(53, "c_held");
        start = 1'b0;
        idle(2, "c_release");
        run_tx(2, 1'b0, 1'b0, -1);
        idle(2, "after_c2");

        run_tx(1, 1'b0, 1'b1, -1);
        start = 1'b0;
        idle(3, "after_b_noise");

        run_tx(3, 1'b0, 1'b0, 11);
        run_tx(4, 1'b0, 1'b0, -1);

        run_tx(7, 1'b0, 1'b0, -1);
        run_tx(5, 1'b0, 1'b0, -1);
        idle(2, "after_b2b");

        repeat (12) begin
            run_tx(int'($urandom_range(0, 7)), 1'b0, 1'($urandom_range(0, 1)), -1);
            start = 1'b0;
            idle(int'($urandom_range(1, 3)), "rand_gap");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
